// File: rtl/mem_arbiter.sv
// Arbiter/sequencer for the shared byte-wide memory/UART bus: grants fetch or
// load-store requests and serialises each one into byte-per-cycle transfers.
module mem_arbiter #(
   parameter bit FAIR = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        clear,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_data,
   input  logic        lsb_req,
   input  logic        lsb_we,
   input  logic [1:0]  lsb_size,
   input  logic        lsb_sext,
   input  logic [31:0] lsb_addr,
   input  logic [31:0] lsb_wdata,
   output logic        lsb_done,
   output logic [31:0] lsb_rdata,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        io_buffer_full
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t      state_r, state_nx_s;
   logic [2:0]  k_r, k_nx_s;
   logic        owner_lsb_r, owner_lsb_nx_s;
   logic        last_lsb_r, last_lsb_nx_s;
   logic [31:0] addr_r, addr_nx_s;
   logic [1:0]  size_r, size_nx_s;
   logic        sext_r, sext_nx_s;
   logic [31:0] wdata_r, wdata_nx_s;
   logic [31:0] buf_r, buf_nx_s;
   logic [31:0] mem_a_r, mem_a_nx_s;
   logic [7:0]  mem_dout_r, mem_dout_nx_s;
   logic        mem_wr_r, mem_wr_nx_s;
   logic        if_done_r, if_done_nx_s;
   logic        lsb_done_r, lsb_done_nx_s;
   logic [31:0] if_data_r, if_data_nx_s;
   logic [31:0] lsb_rdata_r, lsb_rdata_nx_s;

   logic [2:0]  n_s;
   logic        io_s;
   logic        pick_lsb_s;
   logic [31:0] gaddr_s;
   logic [1:0]  cap_idx_s;
   logic [2:0]  wr_idx_s;

   function automatic logic [2:0] byte_count(input logic [1:0] sz);
      case (sz)
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic [31:0] extend_load(input logic [31:0] w, input logic [1:0] sz,
                                               input logic sx);
      case (sz)
         2'b00:   return {{24{sx & w[7]}}, w[7:0]};
         2'b01:   return {{16{sx & w[15]}}, w[15:0]};
         default: return w;
      endcase
   endfunction

   // fetch transactions are stored with the word size so N comes from size_r alone
   assign n_s        = byte_count(size_r);
   assign io_s       = (addr_r[17:16] == 2'b11);
   assign cap_idx_s  = k_r[1:0] - 2'd1;
   assign wr_idx_s   = mem_wr_r ? (k_r + 3'd1) : k_r;
   assign pick_lsb_s = (if_req && lsb_req) ? (FAIR ? ~last_lsb_r : 1'b1) : lsb_req;
   assign gaddr_s    = pick_lsb_s ? lsb_addr : if_addr;

   // State register; a low rdy freezes everything
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= IDLE;
         k_r         <= 3'd0;
         owner_lsb_r <= 1'b0;
         last_lsb_r  <= 1'b1;
         addr_r      <= 32'd0;
         size_r      <= 2'b00;
         sext_r      <= 1'b0;
         wdata_r     <= 32'd0;
         buf_r       <= 32'd0;
         mem_a_r     <= 32'd0;
         mem_dout_r  <= 8'd0;
         mem_wr_r    <= 1'b0;
         if_done_r   <= 1'b0;
         lsb_done_r  <= 1'b0;
         if_data_r   <= 32'd0;
         lsb_rdata_r <= 32'd0;
      end else if (rdy) begin
         state_r     <= state_nx_s;
         k_r         <= k_nx_s;
         owner_lsb_r <= owner_lsb_nx_s;
         last_lsb_r  <= last_lsb_nx_s;
         addr_r      <= addr_nx_s;
         size_r      <= size_nx_s;
         sext_r      <= sext_nx_s;
         wdata_r     <= wdata_nx_s;
         buf_r       <= buf_nx_s;
         mem_a_r     <= mem_a_nx_s;
         mem_dout_r  <= mem_dout_nx_s;
         mem_wr_r    <= mem_wr_nx_s;
         if_done_r   <= if_done_nx_s;
         lsb_done_r  <= lsb_done_nx_s;
         if_data_r   <= if_data_nx_s;
         lsb_rdata_r <= lsb_rdata_nx_s;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_nx_s     = state_r;
      k_nx_s         = k_r;
      owner_lsb_nx_s = owner_lsb_r;
      last_lsb_nx_s  = last_lsb_r;
      addr_nx_s      = addr_r;
      size_nx_s      = size_r;
      sext_nx_s      = sext_r;
      wdata_nx_s     = wdata_r;
      buf_nx_s       = buf_r;
      mem_a_nx_s     = 32'd0;
      mem_dout_nx_s  = 8'd0;
      mem_wr_nx_s    = 1'b0;
      if_done_nx_s   = 1'b0;
      lsb_done_nx_s  = 1'b0;
      if_data_nx_s   = if_data_r;
      lsb_rdata_nx_s = lsb_rdata_r;

      case (state_r)
         IDLE: begin
            if (!clear && (if_req || lsb_req)) begin
               owner_lsb_nx_s = pick_lsb_s;
               last_lsb_nx_s  = pick_lsb_s;
               addr_nx_s      = gaddr_s;
               size_nx_s      = pick_lsb_s ? lsb_size : 2'b10;
               sext_nx_s      = pick_lsb_s & lsb_sext;
               wdata_nx_s     = pick_lsb_s ? lsb_wdata : 32'd0;
               buf_nx_s       = 32'd0;
               k_nx_s         = 3'd0;
               if (pick_lsb_s && lsb_we) begin
                  state_nx_s = WRITE;
                  if ((gaddr_s[17:16] == 2'b11) && io_buffer_full) begin
                     mem_wr_nx_s = 1'b0;
                  end else begin
                     mem_a_nx_s    = gaddr_s;
                     mem_dout_nx_s = lsb_wdata[7:0];
                     mem_wr_nx_s   = 1'b1;
                  end
               end else begin
                  state_nx_s = READ;
                  mem_a_nx_s = gaddr_s;
               end
            end else begin
               state_nx_s = IDLE;
            end
         end
         READ: begin
            if (clear) begin
               state_nx_s = IDLE;
               k_nx_s     = 3'd0;
            end else begin
               k_nx_s = k_r + 3'd1;
               if (k_r != 3'd0) begin
                  buf_nx_s[{cap_idx_s, 3'b000} +: 8] = mem_din;
               end else begin
                  buf_nx_s = buf_r;
               end
               if ((k_r + 3'd1) < n_s) begin
                  mem_a_nx_s = addr_r + {29'd0, k_r} + 32'd1;
               end else begin
                  mem_a_nx_s = 32'd0;
               end
               // clear on this same edge has already aborted, so a flushed read never reports
               if (k_r == n_s) begin
                  state_nx_s = DONE;
                  if (owner_lsb_r) begin
                     lsb_done_nx_s  = 1'b1;
                     lsb_rdata_nx_s = extend_load(buf_nx_s, size_r, sext_r);
                  end else begin
                     if_done_nx_s = 1'b1;
                     if_data_nx_s = buf_nx_s;
                  end
               end else begin
                  state_nx_s = READ;
               end
            end
         end
         WRITE: begin
            if (mem_wr_r && ((k_r + 3'd1) == n_s)) begin
               state_nx_s    = DONE;
               k_nx_s        = n_s;
               lsb_done_nx_s = 1'b1;
            end else begin
               k_nx_s = wr_idx_s;
               if (io_s && io_buffer_full) begin
                  mem_wr_nx_s = 1'b0;
               end else begin
                  mem_a_nx_s    = addr_r + {29'd0, wr_idx_s};
                  mem_dout_nx_s = wdata_r[{wr_idx_s[1:0], 3'b000} +: 8];
                  mem_wr_nx_s   = 1'b1;
               end
            end
         end
         DONE: begin
            state_nx_s = IDLE;
            k_nx_s     = 3'd0;
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   assign if_done   = if_done_r;
   assign if_data   = if_data_r;
   assign lsb_done  = lsb_done_r;
   assign lsb_rdata = lsb_rdata_r;
   assign mem_a     = mem_a_r;
   assign mem_dout  = mem_dout_r;
   // gating with rdy keeps a frozen cycle from committing the held byte twice
   assign mem_wr    = mem_wr_r & rdy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter against a transaction-level
// model of grant order, cycle timing, bus bytes and load extension.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst, rdy, clear;
   logic        if_req, lsb_req, lsb_we, lsb_sext, io_buffer_full;
   logic [31:0] if_addr, lsb_addr, lsb_wdata;
   logic [1:0]  lsb_size;
   logic [7:0]  mem_din = 8'h00;
   logic        if_done, lsb_done, mem_wr;
   logic [31:0] if_data, lsb_rdata, mem_a;
   logic [7:0]  mem_dout;

   int total = 0;
   int bad = 0;

   logic [7:0]  dev [logic [31:0]];
   logic [39:0] wr_log[$];

   mem_arbiter #(.FAIR(1'b1)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
      .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_size(lsb_size), .lsb_sext(lsb_sext),
      .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rd(input logic [31:0] a);
      if (dev.exists(a)) return dev[a];
      else return 8'h00;
   endfunction

   // memory device: read data appears the cycle after the address
   always @(posedge clk) mem_din <= rd(mem_a);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // sample point in the middle of a cycle; commits any bus write to the device
   task automatic sample_cycle();
      @(negedge clk);
      if (mem_wr) begin
         dev[mem_a] = mem_dout;
         wr_log.push_back({mem_a, mem_dout});
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // one isolated transaction; starts and ends just after a rising edge
   task automatic run_txn(input logic is_lsb, input logic we, input logic [1:0] sz,
                          input logic sx, input logic [31:0] a, input logic [31:0] wd,
                          input int io_n, input int rs_at, input int rs_len,
                          input int clr_at, input string tag);
      int n, exp_done, done_cyc, done_cnt, other_cnt;
      logic [31:0] word, expv, got, ai;
      logic [39:0] exp_wr[$];
      n = !is_lsb ? 4 : (sz == 2'd0 ? 1 : (sz == 2'd1 ? 2 : 4));
      exp_done = we ? n + 1 + io_n + rs_len : n + 2;
      word = 32'h0;
      for (int i = 0; i < n; i++) begin
         ai = a + 32'(i);
         if (we) exp_wr.push_back({ai, wd[8*i +: 8]});
         else word = word | ({24'h0, rd(ai)} << (8 * i));
      end
      expv = word;
      if (is_lsb && n == 1) begin
         expv = word & 32'hFF;
         if (sx && expv >= 32'd128) expv = expv + 32'hFFFF_FF00;
      end else if (is_lsb && n == 2) begin
         expv = word & 32'hFFFF;
         if (sx && expv >= 32'd32768) expv = expv + 32'hFFFF_0000;
      end
      wr_log.delete();
      done_cyc = -1; done_cnt = 0; other_cnt = 0; got = 32'h0;
      if_req = !is_lsb; lsb_req = is_lsb;
      if_addr = a; lsb_addr = a; lsb_we = we; lsb_size = sz; lsb_sext = sx; lsb_wdata = wd;
      for (int t = 0; t <= exp_done + 3; t++) begin
         if (done_cnt > 0) begin
            if_req = 1'b0; lsb_req = 1'b0;
         end
         io_buffer_full = (t < io_n);
         rdy = !(t >= rs_at && t < rs_at + rs_len);
         clear = (t == clr_at);
         sample_cycle();
         if (is_lsb ? lsb_done : if_done) begin
            done_cnt++; done_cyc = t; got = is_lsb ? lsb_rdata : if_data;
         end
         if (is_lsb ? if_done : lsb_done) other_cnt++;
         if (!we && t >= 1 && t <= n) begin
            chk({tag, "/rd_addr"}, mem_a, a + 32'(t - 1));
            chk({tag, "/rd_wr"}, {31'd0, mem_wr}, 32'd0);
         end
         if (we && ((t >= 1 && t <= io_n) || (t >= rs_at && t < rs_at + rs_len)))
            chk({tag, "/stall_wr"}, {31'd0, mem_wr}, 32'd0);
         next_cycle();
      end
      rdy = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
      chk({tag, "/done_cnt"}, 32'(done_cnt), 32'd1);
      chk({tag, "/done_cyc"}, 32'(done_cyc), 32'(exp_done));
      chk({tag, "/other_done"}, 32'(other_cnt), 32'd0);
      if (!we) chk({tag, "/data"}, got, expv);
      chk({tag, "/wr_count"}, 32'(wr_log.size()), 32'(exp_wr.size()));
      for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++) begin
         chk({tag, "/wr_addr"}, wr_log[i][39:8], exp_wr[i][39:8]);
         chk({tag, "/wr_byte"}, {24'd0, wr_log[i][7:0]}, {24'd0, exp_wr[i][7:0]});
      end
      chk({tag, "/idle_a"}, mem_a, 32'd0);
   endtask

   initial begin
      int if_cyc[$], lsb_cyc[$], ifcnt;
      logic [31:0] if_dat[$], lsb_dat[$], w0, w1;
      logic is_lsb, we, sx;
      logic [1:0] sz;
      rst = 1'b0; rdy = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
      if_req = 1'b0; lsb_req = 1'b0; lsb_we = 1'b0; lsb_size = 2'b00; lsb_sext = 1'b0;
      if_addr = 32'h0; lsb_addr = 32'h0; lsb_wdata = 32'h0;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst/if_done", {31'd0, if_done}, 32'd0);
      chk("rst/lsb_done", {31'd0, lsb_done}, 32'd0);
      chk("rst/if_data", if_data, 32'd0);
      chk("rst/lsb_rdata", lsb_rdata, 32'd0);
      chk("rst/mem_a", mem_a, 32'd0);
      chk("rst/mem_wr", {31'd0, mem_wr}, 32'd0);
      chk("rst/mem_dout", {24'd0, mem_dout}, 32'd0);
      next_cycle();
      rst = 1'b1;
      next_cycle();

      // tie from reset: IF first, then a repeated tie goes to the LSB
      for (int i = 0; i < 8; i++) dev[32'h400 + 32'(i)] = 8'($urandom);
      dev[32'h200] = 8'hF0;
      w0 = {dev[32'h403], dev[32'h402], dev[32'h401], dev[32'h400]};
      w1 = {dev[32'h407], dev[32'h406], dev[32'h405], dev[32'h404]};
      if_req = 1'b1; if_addr = 32'h400;
      lsb_req = 1'b1; lsb_we = 1'b0; lsb_size = 2'b00; lsb_sext = 1'b1; lsb_addr = 32'h200;
      for (int t = 0; t <= 21; t++) begin
         if (t == 7) if_addr = 32'h404;
         if (lsb_cyc.size() > 0) lsb_req = 1'b0;
         if (if_cyc.size() > 1) if_req = 1'b0;
         sample_cycle();
         if (if_done) begin if_cyc.push_back(t); if_dat.push_back(if_data); end
         if (lsb_done) begin lsb_cyc.push_back(t); lsb_dat.push_back(lsb_rdata); end
         next_cycle();
      end
      chk("tie/if_count", 32'(if_cyc.size()), 32'd2);
      chk("tie/lsb_count", 32'(lsb_cyc.size()), 32'd1);
      if (if_cyc.size() == 2 && lsb_cyc.size() == 1) begin
         chk("tie/if1_cyc", 32'(if_cyc[0]), 32'd6);
         chk("tie/if1_data", if_dat[0], w0);
         chk("tie/lsb_cyc", 32'(lsb_cyc[0]), 32'd10);
         chk("tie/lsb_data", lsb_dat[0], 32'hFFFF_FFF0);
         chk("tie/if2_cyc", 32'(if_cyc[1]), 32'd17);
         chk("tie/if2_data", if_dat[1], w1);
      end

      // fetch only
      dev[32'h100] = 8'h13; dev[32'h101] = 8'h05; dev[32'h102] = 8'h10; dev[32'h103] = 8'h00;
      run_txn(1'b0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, -1, 0, -1, "fetch");
      chk("fetch/word", {dev[32'h103], dev[32'h102], dev[32'h101], dev[32'h100]}, 32'h0010_0513);

      // half store across 0x1FFE/0x1FFF
      run_txn(1'b1, 1'b1, 2'b01, 1'b0, 32'h1FFE, 32'h0000_ABCD, 0, -1, 0, -1, "half_st");
      chk("half_st/mem", {16'd0, dev[32'h1FFF], dev[32'h1FFE]}, 32'h0000_ABCD);

      // UART backpressure for three cycles
      run_txn(1'b1, 1'b1, 2'b00, 1'b0, 32'h0003_0000, 32'h0000_005A, 3, -1, 0, -1, "uart");

      // flush during an IF read, then a request held under clear in IDLE
      for (int i = 0; i < 4; i++) dev[32'h300 + 32'(i)] = 8'($urandom);
      dev[32'h600] = 8'h8C;
      lsb_cyc.delete(); lsb_dat.delete(); ifcnt = 0;
      if_req = 1'b1; if_addr = 32'h300;
      lsb_we = 1'b0; lsb_size = 2'b00; lsb_sext = 1'b0; lsb_addr = 32'h600;
      for (int t = 0; t <= 12; t++) begin
         clear = (t == 3 || t == 4);
         if_req = (t < 4);
         lsb_req = (t >= 4) && (lsb_cyc.size() == 0);
         sample_cycle();
         if (if_done) ifcnt++;
         if (lsb_done) begin lsb_cyc.push_back(t); lsb_dat.push_back(lsb_rdata); end
         if (t == 4) begin
            chk("flush/idle_a", mem_a, 32'd0);
            chk("flush/idle_wr", {31'd0, mem_wr}, 32'd0);
         end
         if (t == 5) chk("flush/no_grant", mem_a, 32'd0);
         if (t == 6) chk("flush/lsb_addr", mem_a, 32'h600);
         next_cycle();
      end
      clear = 1'b0; lsb_req = 1'b0;
      chk("flush/no_if_done", 32'(ifcnt), 32'd0);
      chk("flush/lsb_count", 32'(lsb_cyc.size()), 32'd1);
      if (lsb_cyc.size() == 1) begin
         chk("flush/lsb_cyc", 32'(lsb_cyc[0]), 32'd8);
         chk("flush/lsb_data", lsb_dat[0], 32'h0000_008C);
      end

      // clear during a word store is ignored
      run_txn(1'b1, 1'b1, 2'b10, 1'b0, 32'h500, 32'hDEAD_BEEF, 0, -1, 0, 2, "clr_st");

      // rdy low for two cycles mid-write
      run_txn(1'b1, 1'b1, 2'b10, 1'b0, 32'h700, 32'h1234_5678, 0, 2, 2, -1, "rdy_st");

      // randomized single-requester traffic
      for (int r = 0; r < 24; r++) begin
         logic [31:0] ra;
         is_lsb = 1'($urandom);
         we = is_lsb & 1'($urandom);
         sz = 2'($urandom_range(0, 3));
         sx = 1'($urandom);
         ra = (r % 6 == 5) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3))) : 32'($urandom);
         if (!we) for (int i = 0; i < 4; i++) dev[ra + 32'(i)] = 8'($urandom);
         run_txn(is_lsb, we, sz, sx, ra, 32'($urandom), 0, -1, 0, -1, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
